pong_display_ctrl: RTL and testbench
====================================

PONG_DISPLAY_CTRL -- requirements
Module: pong_display_ctrl

Interface
REQ-001 Parameter DWELL, default 50000, clock cycles a digit is driven per slot (legal >= 2).
REQ-002 Parameter BLANK, default 500, clock cycles all anodes are off between digits (legal >= 0).
REQ-003 Parameter MSG_FRAMES, default 500, full scan frames a message is shown (legal >= 1).
REQ-004 Parameter BLINK_BIT, default 6, frame-counter bit that sets the blink phase (legal 0..15).
REQ-005 clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 score_digits  in  16  score source; [15:12] is the leftmost digit, [3:0] the rightmost.
REQ-008 msg_req  in  1  message requester asks for display time.
REQ-009 msg_digits  in  16  message digits, same packing as score_digits.
REQ-010 blink_mask  in  4  bit i set: digit i blinks (bit 3 is the leftmost digit).
REQ-011 blink_en  in  1  global blink enable.
REQ-012 dmux  out  4  registered digit code for the active digit.
REQ-013 anode  out  4  registered, active-low digit enables; one-hot-low or 4'b1111.
REQ-014 msg_ack  out  1  one-cycle pulse when a message is accepted.
REQ-015 busy  out  1  high while the message source owns the display.

Function
REQ-016 Scan order is digit 3, 2, 1, 0, then repeat; a frame is four slots; each slot is SHOW for DWELL cycles, then BLANK for BLANK cycles.
REQ-017 In SHOW for digit i, anode is low only in bit i (3:0111, 2:1011, 1:1101, 0:1110); in BLANK, anode = 4'b1111 and dmux holds its last value.
REQ-018 With BLANK = 0, the BLANK phase is skipped and the slots are back-to-back.
REQ-019 The active source's nibble for digit i is snapshotted into dmux at the first SHOW cycle of the slot and held for the whole slot; input changes mid-slot are not visible.
REQ-020 Source FSM states are SCORE and MSG; the reset state is SCORE.
REQ-021 Source switches happen only at a frame boundary, which is the cycle after digit 0's slot ends.
REQ-022 SCORE->MSG: at a boundary, msg_req = 1 and the eligible flag is set -> latch msg_digits into the message register, pulse msg_ack for exactly that cycle, and set busy.
REQ-023 While in MSG, the latched message is displayed; msg_digits and msg_req changes are ignored.
REQ-024 MSG->SCORE at the boundary ending frame MSG_FRAMES; busy clears in the same cycle.
REQ-025 Fairness: after MSG->SCORE, at least one full SCORE frame is shown before msg_req is eligible again.
REQ-026 The frame counter is 16-bit and wraps; it increments at every boundary.
REQ-027 Blink: if blink_en = 1, blink_mask[i] = 1 and framecnt[BLINK_BIT] = 1, then anode stays 4'b1111 during the SHOW of digit i; slot timing is unchanged.
REQ-028 Blink applies in both SCORE and MSG.
REQ-029 Counters are unsigned, sized with $clog2(param+1), and never overflow at legal parameter values.

Reset
REQ-030 While rst_n = 0: dmux = 4'h0, anode = 4'b1111, msg_ack = 0, busy = 0, source = SCORE, eligible = 1, framecnt = 0, digit index = 3, phase = SHOW, and the slot counter = 0.
REQ-031 Reset asserted mid-slot or mid-message forces the REQ-030 values immediately; no message completes and no msg_ack is issued.
REQ-032 At the first rising clk edge after rst_n rises: anode = 4'b0111 and dmux = score_digits[15:12].

Structure
REQ-033 Package pong_disp_pkg holds the source-state enum, the phase enum (SHOW/BLANK) and the ANODE_OFF / anode-pattern constants.
REQ-034 One sub-module, disp_slot_timer, generates the SHOW/BLANK phase, the digit index and the frame-boundary strobe; pong_display_ctrl owns arbitration, blink and the output registers.

Verification
REQ-035 Bench parameters are DWELL=4, BLANK=2, MSG_FRAMES=2 and BLINK_BIT=0 unless stated otherwise.
REQ-036 Reset release, score_digits=16'h1234 -> anode follows 0111x4, 1111x2, 1011x4, 1111x2, 1101x4, 1111x2, 1110x4, 1111x2, with dmux 1,2,3,4 in the SHOW phases; the frame repeats every 24 cycles.
REQ-037 msg_req=1 mid-frame, msg_digits=16'hABCD -> msg_ack is a single pulse at the next boundary; busy is high for 48 cycles and A,B,C,D are shown; score resumes; with msg_req held, the second ack comes 24 cycles after busy falls.
REQ-038 Change msg_digits to 16'h0000 while busy -> the display still shows ABCD.
REQ-039 blink_en=1, blink_mask=4'b0100 -> on odd frames digit 2's slot shows anode 1111 for all 6 cycles; on even frames it shows 1011; the other digits are unaffected.
REQ-040 Assert rst_n=0 during message frame 1 -> on the same edge anode=1111, busy=0 and msg_ack=0; after release the display resumes per REQ-032.
REQ-041 BLANK=0, score_digits changed mid-slot -> anode has no 1111 cycles, and the new value appears only from the next slot.

Source files
------------

// File: rtl/pong_disp_pkg.sv
// rtl/pong_disp_pkg.sv - shared types and anode constants for the pong display controller
package pong_disp_pkg;

  // Which source currently owns the display
  typedef enum logic {
    SRC_SCORE = 1'b0,
    SRC_MSG   = 1'b1
  } src_t;

  // Slot phase: digit driven, or all anodes off between digits
  typedef enum logic {
    PH_SHOW  = 1'b0,
    PH_BLANK = 1'b1
  } phase_t;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Active-low one-hot anode pattern for digit idx (3 -> 0111, 0 -> 1110)
  function automatic logic [3:0] anode_pattern(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/disp_slot_timer.sv
// rtl/disp_slot_timer.sv - SHOW/BLANK phase, digit index and frame-boundary strobe
module disp_slot_timer
  import pong_disp_pkg::*;
#(
  parameter int DWELL = 50000,
  parameter int BLANK = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  output phase_t     phase,
  output logic [1:0] idx,
  output logic       slot_start,
  output logic       frame_tick
);

  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

  logic [CW-1:0] cnt;
  logic          show_last;
  logic          slot_end;

  // Decode end of phase/slot; with no blanking the slot ends with its SHOW phase
  always_comb begin
    show_last  = (phase == PH_SHOW) && (cnt == SHOW_LAST);
    slot_end   = 1'b0;
    if (BLANK == 0) begin
      slot_end = show_last;
    end else begin
      slot_end = (phase == PH_BLANK) && (cnt == BLANK_LAST);
    end
    slot_start = (phase == PH_SHOW) && (cnt == '0);
    frame_tick = slot_end && (idx == 2'd0);
  end

  // Phase counter and digit walk 3,2,1,0,3,...
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= PH_SHOW;
      idx   <= 2'd3;
    end else if (slot_end) begin
      cnt   <= '0;
      phase <= PH_SHOW;
      idx   <= idx - 2'd1;
    end else if (show_last) begin
      cnt   <= '0;
      phase <= PH_BLANK;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pong_display_ctrl.sv
// rtl/pong_display_ctrl.sv - four-digit scan with score/message arbitration and blink
module pong_display_ctrl
  import pong_disp_pkg::*;
#(
  parameter int DWELL      = 50000,
  parameter int BLANK      = 500,
  parameter int MSG_FRAMES = 500,
  parameter int BLINK_BIT  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] score_digits,
  input  logic        msg_req,
  input  logic [15:0] msg_digits,
  input  logic [3:0]  blink_mask,
  input  logic        blink_en,
  output logic [3:0]  dmux,
  output logic [3:0]  anode,
  output logic        msg_ack,
  output logic        busy
);

  localparam int MW = $clog2(MSG_FRAMES + 1);
  localparam logic [MW-1:0] MF_LAST = MW'(MSG_FRAMES - 1);

  phase_t        phase;
  logic [1:0]    idx;
  logic          slot_start;
  logic          frame_tick;

  src_t          src, src_nxt;
  logic          accept, done;
  logic          eligible;
  logic [15:0]   framecnt;
  logic [15:0]   msg_reg;
  logic [MW-1:0] msg_cnt;
  logic [15:0]   src_data;
  logic [3:0]    nibble;
  logic          blink_off;

  disp_slot_timer #(
    .DWELL(DWELL),
    .BLANK(BLANK)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .phase     (phase),
    .idx       (idx),
    .slot_start(slot_start),
    .frame_tick(frame_tick)
  );

  // Source FSM next state: switches only at frame boundaries
  always_comb begin
    src_nxt = src;
    accept  = 1'b0;
    done    = 1'b0;
    case (src)
      SRC_SCORE: begin
        if (frame_tick && msg_req && eligible) begin
          accept  = 1'b1;
          src_nxt = SRC_MSG;
        end
      end
      SRC_MSG: begin
        if (frame_tick && (msg_cnt == MF_LAST)) begin
          done    = 1'b1;
          src_nxt = SRC_SCORE;
        end
      end
      default: src_nxt = SRC_SCORE;
    endcase
  end

  // Source state, message latch, frame counters and the fairness flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src      <= SRC_SCORE;
      eligible <= 1'b1;
      framecnt <= '0;
      msg_reg  <= '0;
      msg_cnt  <= '0;
      msg_ack  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      src     <= src_nxt;
      msg_ack <= accept;
      busy    <= (src_nxt == SRC_MSG);
      if (frame_tick) framecnt <= framecnt + 16'd1;
      if (accept) begin
        msg_reg <= msg_digits;
        msg_cnt <= '0;
      end else if ((src == SRC_MSG) && frame_tick && !done) begin
        msg_cnt <= msg_cnt + MW'(1);
      end
      // A score frame starting after a message re-arms the requester; it is
      // complete by the next boundary, which is where eligibility is used.
      if (done) begin
        eligible <= 1'b0;
      end else if ((src == SRC_SCORE) && slot_start && (idx == 2'd3)) begin
        eligible <= 1'b1;
      end
    end
  end

  // Select the active source nibble and decide whether this digit is blinked off
  always_comb begin
    src_data  = (src == SRC_MSG) ? msg_reg : score_digits;
    nibble    = src_data[{idx, 2'b00} +: 4];
    blink_off = blink_en && blink_mask[idx] && framecnt[BLINK_BIT];
  end

  // Output registers: digit code snapshotted at slot start, anodes follow phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmux  <= 4'h0;
      anode <= ANODE_OFF;
    end else if (phase == PH_SHOW) begin
      anode <= blink_off ? ANODE_OFF : anode_pattern(idx);
      if (slot_start) dmux <= nibble;
    end else begin
      anode <= ANODE_OFF;
    end
  end

endmodule

// File: tb/tb_pong_display_ctrl.sv
// tb/tb_pong_display_ctrl.sv - directed self-checking bench for pong_display_ctrl
module tb_pong_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] score_digits, msg_digits, score0;
  logic        msg_req, blink_en;
  logic [3:0]  blink_mask;
  logic [3:0]  dmux, anode, dmux0, anode0;
  logic        msg_ack, busy, msg_ack0, busy0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pong_display_ctrl #(.DWELL(4), .BLANK(2), .MSG_FRAMES(2), .BLINK_BIT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .score_digits(score_digits), .msg_req(msg_req),
    .msg_digits(msg_digits), .blink_mask(blink_mask), .blink_en(blink_en),
    .dmux(dmux), .anode(anode), .msg_ack(msg_ack), .busy(busy)
  );

  pong_display_ctrl #(.DWELL(4), .BLANK(0), .MSG_FRAMES(2), .BLINK_BIT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .score_digits(score0), .msg_req(1'b0),
    .msg_digits(16'h0000), .blink_mask(4'b0000), .blink_en(1'b0),
    .dmux(dmux0), .anode(anode0), .msg_ack(msg_ack0), .busy(busy0)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_anode(input int p, input int dw, input int bl);
    int s, off;
    s   = p / (dw + bl);
    off = p % (dw + bl);
    return (off < dw) ? (15 - (1 << (3 - s))) : 15;
  endfunction

  function automatic int exp_digit(input int p, input int dw, input int bl, input int digits);
    int s;
    s = p / (dw + bl);
    return (digits >> (4 * (3 - s))) & 15;
  endfunction

  initial begin
    int f, p, s, digits;
    rst_n        = 1'b0;
    score_digits = 16'h1234;
    score0       = 16'h1234;
    msg_digits   = 16'h0000;
    msg_req      = 1'b0;
    blink_en     = 1'b0;
    blink_mask   = 4'b0000;
    repeat (3) @(negedge clk);

    check("reset_anode", int'(anode), 15);
    check("reset_dmux", int'(dmux), 0);
    check("reset_ack", int'(msg_ack), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_anode_b0", int'(anode0), 15);

    rst_n = 1'b1;
    for (int k = 1; k <= 150; k++) begin
      @(posedge clk);
      @(negedge clk);
      f = (k - 1) / 24;
      p = (k - 1) % 24;
      case (f)
        0:       digits = 'h1234;
        1:       digits = 'h1678;
        2, 5:    digits = 'h5678;
        3, 4:    digits = 'hABCD;
        default: digits = 'h0000;
      endcase
      check($sformatf("anode_c%0d", k), int'(anode), exp_anode(p, 4, 2));
      check($sformatf("dmux_c%0d", k), int'(dmux), exp_digit(p, 4, 2, digits));
      check($sformatf("ack_c%0d", k), int'(msg_ack), (k == 72 || k == 144) ? 1 : 0);
      check($sformatf("busy_c%0d", k), int'(busy),
            ((k >= 72 && k <= 119) || k >= 144) ? 1 : 0);
      if (k == 26) score_digits = 16'h5678;
      if (k == 50) begin
        msg_req    = 1'b1;
        msg_digits = 16'hABCD;
      end
      if (k == 80)  msg_digits = 16'h0000;
      if (k == 144) msg_req = 1'b0;
    end

    #2 rst_n = 1'b0;
    #1;
    check("midmsg_rst_anode", int'(anode), 15);
    check("midmsg_rst_busy", int'(busy), 0);
    check("midmsg_rst_ack", int'(msg_ack), 0);
    check("midmsg_rst_dmux", int'(dmux), 0);

    blink_en   = 1'b1;
    blink_mask = 4'b0100;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(posedge clk);
      @(negedge clk);
      f = (k - 1) / 24;
      p = (k - 1) % 24;
      s = p / 6;
      if (f == 1 && s == 1) begin
        check($sformatf("blink_anode_c%0d", k), int'(anode), 15);
      end else begin
        check($sformatf("blk_anode_c%0d", k), int'(anode), exp_anode(p, 4, 2));
        check($sformatf("blk_dmux_c%0d", k), int'(dmux), exp_digit(p, 4, 2, 'h5678));
      end
      if (k <= 32) begin
        p = (k - 1) % 16;
        digits = (k <= 16) ? 'h1876 : 'h9876;
        check($sformatf("b0_anode_c%0d", k), int'(anode0), exp_anode(p, 4, 0));
        check($sformatf("b0_dmux_c%0d", k), int'(dmux0), exp_digit(p, 4, 0, digits));
      end
      if (k == 2) score0 = 16'h9876;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
